frame_buffer_dbl: RTL and testbench



---
 rtl/frame_buffer_dbl_if.sv | 9 +
 rtl/frame_buffer_dbl.sv | 193 +++++++++++++++++++
 tb/tb_frame_buffer_dbl.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_dbl_if.sv
// Byte stream handshake into the double-buffered frame store.
interface frame_buffer_dbl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered LED frame store: framed byte stream in, tear-free swap on scan frame_end.
// Optional trailing XOR checksum byte when FB_CHECKSUM_EN is defined.
module frame_buffer_dbl #(
    parameter int         MATRIX_W    = 16,
    parameter int         MATRIX_H    = 16,
    parameter int         COLOR_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         AW          = $clog2(MATRIX_W * MATRIX_H)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    frame_buffer_dbl_if.slave      stream,
    input  logic                   frame_end,
    input  logic [AW-1:0]          read_addr,
    output logic [COLOR_DEPTH-1:0] pixel_data,
    output logic [1:0]             state,
    output logic                   frame_swapped,
    output logic                   err_timeout,
    output logic [15:0]            frame_count
`ifdef FB_CHECKSUM_EN
    ,
    output logic                   err_csum
`endif
);

    localparam int NPIX = MATRIX_W * MATRIX_H;
    localparam int BPP  = (COLOR_DEPTH + 7) / 8;
    localparam int BW   = BPP * 8;
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECV    = 2'b01,
        PENDING = 2'b10,
        CHECK   = 2'b11
    } state_t;

`ifdef FB_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHECK;
`else
    localparam state_t AFTER_PAYLOAD = PENDING;
`endif

    state_t                 st, st_next;
    logic [AW-1:0]          write_addr;
    logic [1:0]             byte_idx;
    logic [BW-1:0]          asm_q, asm_next;
    logic [TW-1:0]          tmo_cnt;
    logic                   buffer_sel, front_valid;
    logic                   ready, accept, sync_hit, pix_we, swap, tmo_hit, tmo_expired;
    logic                   in_range;
    logic [COLOR_DEPTH-1:0] rd_word;
    logic [COLOR_DEPTH-1:0] mem0 [NPIX];
    logic [COLOR_DEPTH-1:0] mem1 [NPIX];
`ifdef FB_CHECKSUM_EN
    logic [7:0]             csum;
    logic                   csum_bad;
`endif

`ifdef FB_CHECKSUM_EN
    assign ready = (st == IDLE) || (st == RECV) || (st == CHECK);
`else
    assign ready = (st == IDLE) || (st == RECV);
`endif
    assign stream.in_ready = ready;
    assign accept          = stream.in_valid && ready;
    assign state           = st;
    assign asm_next        = BW'({asm_q, stream.in_data});
    assign tmo_expired     = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_next;
    end

    always_comb begin
        st_next  = st;
        sync_hit = 1'b0;
        pix_we   = 1'b0;
        swap     = 1'b0;
        tmo_hit  = 1'b0;
`ifdef FB_CHECKSUM_EN
        csum_bad = 1'b0;
`endif
        case (st)
            IDLE: begin
                if (accept && stream.in_data == SYNC_BYTE) begin
                    sync_hit = 1'b1;
                    st_next  = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    if (byte_idx == 2'(BPP - 1)) begin
                        pix_we = 1'b1;
                        if (write_addr == AW'(NPIX - 1)) st_next = AFTER_PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    st_next = IDLE;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    swap    = 1'b1;
                    st_next = IDLE;
                end
            end
`ifdef FB_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (stream.in_data == csum) begin
                        st_next = PENDING;
                    end else begin
                        csum_bad = 1'b1;
                        st_next  = IDLE;
                    end
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    st_next = IDLE;
                end
            end
`endif
            default: st_next = IDLE;
        endcase
    end

    assign in_range = {1'b0, read_addr} < (AW + 1)'(NPIX);
    assign rd_word  = buffer_sel ? mem1[read_addr] : mem0[read_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_addr    <= '0;
            byte_idx      <= '0;
            asm_q         <= '0;
            tmo_cnt       <= '0;
            buffer_sel    <= 1'b0;
            front_valid   <= 1'b0;
            frame_count   <= '0;
            frame_swapped <= 1'b0;
            err_timeout   <= 1'b0;
            pixel_data    <= '0;
`ifdef FB_CHECKSUM_EN
            csum          <= '0;
            err_csum      <= 1'b0;
`endif
        end else begin
            frame_swapped <= swap;
            err_timeout   <= tmo_hit;
`ifdef FB_CHECKSUM_EN
            err_csum      <= csum_bad;
`endif
            if (sync_hit) begin
                write_addr <= '0;
                byte_idx   <= '0;
                tmo_cnt    <= '0;
`ifdef FB_CHECKSUM_EN
                csum       <= '0;
`endif
            end else if (st == RECV || st == CHECK) begin
                tmo_cnt <= accept ? '0 : tmo_cnt + TW'(1);
                if (st == RECV && accept) begin
                    asm_q <= asm_next;
`ifdef FB_CHECKSUM_EN
                    csum  <= csum ^ stream.in_data;
`endif
                    if (byte_idx == 2'(BPP - 1)) begin
                        byte_idx   <= '0;
                        write_addr <= write_addr + AW'(1);
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
            end
            if (swap) begin
                buffer_sel  <= ~buffer_sel;
                front_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
            pixel_data <= (front_valid && in_range) ? rd_word : '0;
        end
    end

    // buffer_sel names the front bank; only the other bank is ever written.
    always_ff @(posedge clk) begin
        if (pix_we) begin
            if (buffer_sel) mem0[write_addr] <= asm_next[COLOR_DEPTH-1:0];
            else            mem1[write_addr] <= asm_next[COLOR_DEPTH-1:0];
        end
    end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Scoreboard bench for frame_buffer_dbl (8-bit 16x16 and 12-bit 4x4 instances).
module tb_frame_buffer_dbl;

    localparam int NPIX = 256;
    localparam int N12  = 16;
    localparam int TMO  = 300;

    typedef struct {
        int          addr;
        logic [11:0] val;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_end, fe12;
    logic [7:0]  read_addr;
    logic [3:0]  ra12;
    logic [7:0]  pixel_data;
    logic [11:0] pix12;
    logic [1:0]  state, state12;
    logic        frame_swapped, err_timeout, swapped12, tmo12;
    logic [15:0] frame_count, fc12;
`ifdef FB_CHECKSUM_EN
    logic        err_csum, csum12;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  front_m [NPIX];
    logic [7:0]  back_m  [NPIX];
    bit          fv;
    logic [15:0] fc_m;
    logic [11:0] front12 [N12];
    logic [11:0] back12  [N12];
    bit          fv12;
    rd_t         rdq[$];

    frame_buffer_dbl_if bus();
    frame_buffer_dbl_if bus12();

    always #5 clk = ~clk;

    frame_buffer_dbl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .stream(bus), .frame_end(frame_end),
        .read_addr(read_addr), .pixel_data(pixel_data), .state(state),
        .frame_swapped(frame_swapped), .err_timeout(err_timeout), .frame_count(frame_count)
`ifdef FB_CHECKSUM_EN
        , .err_csum(err_csum)
`endif
    );

    frame_buffer_dbl #(.MATRIX_W(4), .MATRIX_H(4), .COLOR_DEPTH(12), .TIMEOUT_CYC(TMO)) dut12 (
        .clk(clk), .rst_n(rst_n), .stream(bus12), .frame_end(fe12),
        .read_addr(ra12), .pixel_data(pix12), .state(state12),
        .frame_swapped(swapped12), .err_timeout(tmo12), .frame_count(fc12)
`ifdef FB_CHECKSUM_EN
        , .err_csum(csum12)
`endif
    );

    function automatic logic [7:0] pix_val(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'(255 - i);
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit fe);
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        frame_end    = fe;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready byte=%h got %b want 1", b, bus.in_ready);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.in_valid = 1'b0;
        frame_end    = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit fe_last, input bit corrupt);
        logic [7:0] v, cs;
        cs = 8'h00;
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < NPIX; i++) begin
            v = pix_val(kind, i);
            back_m[i] = v;
            cs ^= v;
`ifdef FB_CHECKSUM_EN
            send_byte(v, 1'b0);
`else
            send_byte(v, fe_last && (i == NPIX - 1));
`endif
        end
`ifdef FB_CHECKSUM_EN
        send_byte(corrupt ? (cs ^ 8'h01) : cs, fe_last);
`else
        if (corrupt) cs = ~cs;
`endif
        end_stream();
    endtask

    task automatic pulse_frame_end(input bit expect_swap);
        int seen;
        seen = 0;
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (frame_swapped) seen++;
            @(negedge clk);
        end
        if (expect_swap) begin
            fv   = 1'b1;
            fc_m = fc_m + 16'd1;
            for (int i = 0; i < NPIX; i++) front_m[i] = back_m[i];
        end
        checks++;
        if (seen != (expect_swap ? 1 : 0)) begin
            errors++;
            $display("FAIL swap_pulses got %0d want %0d", seen, expect_swap ? 1 : 0);
        end
        checks++;
        if (frame_count !== fc_m) begin
            errors++;
            $display("FAIL frame_count got %0d want %0d", frame_count, fc_m);
        end
    endtask

    task automatic read_all();
        rd_t r;
        for (int a = 0; a <= NPIX; a++) begin
            @(negedge clk);
            if (rdq.size() > 0) begin
                r = rdq.pop_front();
                checks++;
                if (pixel_data !== r.val[7:0]) begin
                    errors++;
                    $display("FAIL read addr=%0d got %h want %h", r.addr, pixel_data, r.val[7:0]);
                end
            end
            if (a < NPIX) begin
                read_addr = 8'(a);
                r.addr = a;
                r.val  = fv ? {4'h0, front_m[a]} : 12'h000;
                rdq.push_back(r);
            end
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] want_st, input logic want_rdy);
        checks++;
        if (state !== want_st || bus.in_ready !== want_rdy) begin
            errors++;
            $display("FAIL %s state/ready got %b/%b want %b/%b", name, state, bus.in_ready, want_st, want_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fv    = 1'b0;
        fc_m  = 16'd0;
        fv12  = 1'b0;
        @(negedge clk);
        check_state("reset", 2'b00, 1'b1);
        checks++;
        if (frame_count !== 16'd0 || frame_swapped !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got fc=%0d sw=%b to=%b want 0 0 0", frame_count, frame_swapped, err_timeout);
        end
        read_all();
    endtask

    task automatic test_basic_frame();
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hFF, 1'b0);
        end_stream();
        check_state("idle_drop", 2'b00, 1'b1);
        send_frame(0, 1'b0, 1'b0);
        check_state("pending", 2'b10, 1'b0);
        pulse_frame_end(1'b1);
        check_state("after_swap", 2'b00, 1'b1);
        read_all();
    endtask

    task automatic test_swap_boundary();
        int seen, rdy_hi;
        seen = 0;
        rdy_hi = 0;
        send_frame(1, 1'b1, 1'b0);
        for (int c = 0; c < 50; c++) begin
            if (frame_swapped) seen++;
            if (bus.in_ready !== 1'b0) rdy_hi++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || rdy_hi != 0) begin
            errors++;
            $display("FAIL early_swap got swaps=%0d ready_hi=%0d want 0 0", seen, rdy_hi);
        end
        check_state("still_pending", 2'b10, 1'b0);
        pulse_frame_end(1'b1);
        read_all();
    endtask

    task automatic test_timeout();
        int cyc;
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 100; i++) send_byte(8'h3C, 1'b0);
        end_stream();
        cyc = 0;
        while (!err_timeout && cyc < TMO + 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != TMO) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want %0d", cyc, TMO);
        end
        check_state("timeout_idle", 2'b00, 1'b1);
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width got %b want 0", err_timeout);
        end
        pulse_frame_end(1'b0);
        read_all();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 50; i++) send_byte(8'h77, 1'b0);
        end_stream();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fv    = 1'b0;
        fc_m  = 16'd0;
        fv12  = 1'b0;
        @(negedge clk);
        check_state("mid_reset", 2'b00, 1'b1);
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_count got %0d want 0", frame_count);
        end
        read_all();
        send_frame(2, 1'b0, 1'b0);
        pulse_frame_end(1'b1);
        read_all();
    endtask

    task automatic send12(input logic [7:0] b);
        @(negedge clk);
        bus12.in_data  = b;
        bus12.in_valid = 1'b1;
    endtask

    task automatic test_depth12();
        logic [11:0] v;
        logic [3:0]  n;
        logic [7:0]  cs;
        int          seen;
        rd_t         r;
        cs = 8'h00;
        send12(8'hA5);
        for (int i = 0; i < N12; i++) begin
            n = 4'(i);
            v = (i == 0) ? 12'hABC : {n, ~n, 4'h3};
            back12[i] = v;
            send12({4'h0, v[11:8]});
            send12(v[7:0]);
            cs ^= {4'h0, v[11:8]} ^ v[7:0];
        end
`ifdef FB_CHECKSUM_EN
        send12(cs);
`endif
        @(negedge clk);
        bus12.in_valid = 1'b0;
        checks++;
        if (state12 !== 2'b10) begin
            errors++;
            $display("FAIL depth12_pending got %b want 10", state12);
        end
        seen = 0;
        @(negedge clk);
        fe12 = 1'b1;
        @(negedge clk);
        fe12 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (swapped12) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 1 || fc12 !== 16'd1) begin
            errors++;
            $display("FAIL depth12_swap got pulses=%0d count=%0d want 1 1", seen, fc12);
        end
        fv12 = 1'b1;
        for (int i = 0; i < N12; i++) front12[i] = back12[i];
        for (int a = 0; a <= N12; a++) begin
            @(negedge clk);
            if (rdq.size() > 0) begin
                r = rdq.pop_front();
                checks++;
                if (pix12 !== r.val) begin
                    errors++;
                    $display("FAIL read12 addr=%0d got %h want %h", r.addr, pix12, r.val);
                end
            end
            if (a < N12) begin
                ra12   = 4'(a);
                r.addr = a;
                r.val  = fv12 ? front12[a] : 12'h000;
                rdq.push_back(r);
            end
        end
    endtask

`ifdef FB_CHECKSUM_EN
    task automatic test_checksum();
        send_frame(1, 1'b0, 1'b1);
        checks++;
        if (err_csum !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad_pulse got %b want 1", err_csum);
        end
        check_state("csum_bad_idle", 2'b00, 1'b1);
        pulse_frame_end(1'b0);
        read_all();
        send_frame(0, 1'b0, 1'b0);
        checks++;
        if (err_csum !== 1'b0) begin
            errors++;
            $display("FAIL csum_good_pulse got %b want 0", err_csum);
        end
        check_state("csum_good_pending", 2'b10, 1'b0);
        pulse_frame_end(1'b1);
        read_all();
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        frame_end      = 1'b0;
        fe12           = 1'b0;
        read_addr      = 8'd0;
        ra12           = 4'd0;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus12.in_data  = 8'h00;
        bus12.in_valid = 1'b0;
        test_reset();
        test_basic_frame();
        test_swap_boundary();
        test_timeout();
        test_reset_midframe();
        test_depth12();
`ifdef FB_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
